multichannel_waveform_sequencer: RTL and testbench
==================================================

Name: multichannel_waveform_sequencer

Overview:
- Parametrised playback-address generator for the OSERDES function-generator path.
- Drives NUM_CHANNELS independent read addresses into dual-port waveform memories.
- Start/end/mode registers come from the SPI register file; each channel plays a programmable address window continuously, once per trigger, or continuously after a trigger.
- Emits per-channel sync pulses delayed to line up with serialized output, and a done flag.

Parameters:
NUM_CHANNELS, 4, number of independent playback channels (1..16)
ADDR_WIDTH, 14, width of each read address (memory depth 2**ADDR_WIDTH words)
SYNC_DELAY, 3, cycles from sync_raw to sync_out; must be >= 1

Ports:
clock  input  1  word clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset
start_address  input  NUM_CHANNELS*ADDR_WIDTH  channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]; first address played
end_address  input  NUM_CHANNELS*(ADDR_WIDTH+1)  channel i at [i*(ADDR_WIDTH+1) +: ADDR_WIDTH+1]; exclusive end
mode  input  NUM_CHANNELS*2  per channel: 0 OFF, 1 CONTINUOUS, 2 ONESHOT, 3 TRIGGERED_CONTINUOUS
trigger  input  NUM_CHANNELS  per-channel single-cycle start request
restart_all  input  1  global resync of all RUNNING channels
read_address  output  NUM_CHANNELS*ADDR_WIDTH  registered memory read address per channel
running  output  NUM_CHANNELS  channel in RUNNING state
done  output  NUM_CHANNELS  one-cycle pulse when a ONESHOT play completes
config_error  output  NUM_CHANNELS  end_address <= start_address on that channel
sync_out  output  NUM_CHANNELS  sync_raw delayed SYNC_DELAY cycles

Behaviour:
- Reset (reset=0, async):
  - read_address=0; state=IDLE; running=0; done=0; sync_raw, sync_out, sync pipeline=0.
  - Shadow start/end registers=0. config_error is combinational and unaffected by reset.
- Per-channel FSM, states IDLE and RUNNING; channels fully independent except restart_all.
- Shadow registers (shadow_start, shadow_end):
  - Load from inputs every IDLE cycle, on every wrap, and on restart.
  - Input changes during RUNNING take effect only at the next wrap or restart.
- config_error = (end_address <= start_address), unsigned compare at ADDR_WIDTH+1 bits.
  - While asserted, IDLE->RUNNING is blocked.
  - A channel already RUNNING continues on its shadow values.
- IDLE, each cycle:
  - read_address <= start_address.
  - go = !config_error && (mode==1 || ((mode==2 || mode==3) && trigger)).
  - On go: state <= RUNNING, sync_raw <= 1 for one cycle. First played address is start, valid the cycle after go.
- RUNNING, priority high to low:
  1. mode==0: state <= IDLE, read_address <= start_address, no sync, no done.
  2. restart_all: read_address <= start_address, reload shadows, sync_raw <= 1.
  3. read_address == shadow_end-1 and mode==2: state <= IDLE, read_address <= start_address, done <= 1 for one cycle, no sync.
  4. read_address == shadow_end-1, mode 1 or 3: read_address <= start_address, reload shadows, sync_raw <= 1.
  5. Otherwise read_address <= read_address+1.
- Trigger while RUNNING is ignored (no retrigger). Trigger in the same cycle as ONESHOT completion is also ignored; the channel returns to IDLE and needs a new trigger.
- Full-depth window: start=0, end=2**ADDR_WIDTH is legal; the address reaches all-ones and then wraps to start.
- A window of length 1 (end=start+1) outputs a constant address. In continuous modes sync pulses every cycle.
- restart_all in IDLE has no effect.
- running = (state==RUNNING), registered.
- sync_out[i] = sync_raw[i] through a SYNC_DELAY-stage shift register.
- Reset asserted mid-play aborts immediately to reset values. After release the channel re-enters IDLE, and mode 1 restarts on the first clock edge.

Test Plan:
- Continuous: ch0 mode=1, start=4, end=8, release reset -> read_address 4,5,6,7,4,5,...; sync_raw at go and on each 7->4 wrap; sync_out 3 cycles later.
- Oneshot: ch1 mode=2, start=10, end=13, trigger pulse -> 10,11,12, then done=1 one cycle, running=0, address held 10; second trigger mid-play ignored; trigger after done replays.
- Shadowing: ch0 running 4..8, change start=20, end=22 at address 5 -> 6,7,20,21,20,21; sync on each wrap.
- Config error and mode-off: ch2 start=9, end=9, mode=1 -> config_error=1, stays IDLE at 9; mode 1->0 while RUNNING at address 6 -> next cycle IDLE, address=start, no done.
- restart_all: ch0 (4..8) at 6 and ch3 (0..16384, ADDR_WIDTH=14) at 100 -> both jump to start next cycle, both sync; ch3 later wraps 16383->0.
- Async reset mid-play: drop reset between edges -> outputs zero immediately; release -> mode-1 channel restarts from start with sync.

Source files
------------

// File: rtl/multichannel_waveform_sequencer.sv
// Playback-address generator for the OSERDES function-generator path.
// Each channel walks its own [start, end) window into a waveform memory and emits aligned sync pulses.
module multichannel_waveform_sequencer #(
  parameter int NUM_CHANNELS = 4,
  parameter int ADDR_WIDTH   = 14,
  parameter int SYNC_DELAY   = 3
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0]     start_address,
  input  logic [NUM_CHANNELS*(ADDR_WIDTH+1)-1:0] end_address,
  input  logic [NUM_CHANNELS*2-1:0]              mode,
  input  logic [NUM_CHANNELS-1:0]                trigger,
  input  logic                                  restart_all,
  output logic [NUM_CHANNELS*ADDR_WIDTH-1:0]     read_address,
  output logic [NUM_CHANNELS-1:0]                running,
  output logic [NUM_CHANNELS-1:0]                done,
  output logic [NUM_CHANNELS-1:0]                config_error,
  output logic [NUM_CHANNELS-1:0]                sync_out
);

  localparam int AW1 = ADDR_WIDTH + 1;

  typedef enum logic {
    IDLE    = 1'b0,
    RUNNING = 1'b1
  } state_t;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : gChannel
    logic [ADDR_WIDTH-1:0] startIn;
    logic [AW1-1:0]        endIn;
    logic [1:0]            modeIn;
    logic                  go;
    logic                  atEnd;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [AW1-1:0]        shadowEnd_q;
    logic                  done_q;
    logic                  syncRaw_q;
    logic [SYNC_DELAY-1:0] syncPipe_q;

    assign startIn = start_address[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign endIn   = end_address[i*AW1 +: AW1];
    assign modeIn  = mode[i*2 +: 2];

    assign config_error[i] = (endIn <= {1'b0, startIn});
    assign go    = !config_error[i] &&
                   ((modeIn == 2'd1) || (((modeIn == 2'd2) || (modeIn == 2'd3)) && trigger[i]));
    // The end is compared at ADDR_WIDTH+1 bits so a full-depth window wraps at all-ones.
    assign atEnd = ({1'b0, addr_q} == (shadowEnd_q - AW1'(1)));

    // The start address is consumed straight from the input only at reload points, so only the end needs shadowing.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        state_q     <= IDLE;
        addr_q      <= '0;
        shadowEnd_q <= '0;
        done_q      <= 1'b0;
        syncRaw_q   <= 1'b0;
        syncPipe_q  <= '0;
      end else begin
        done_q     <= 1'b0;
        syncRaw_q  <= 1'b0;
        syncPipe_q <= (syncPipe_q << 1) | SYNC_DELAY'(syncRaw_q);
        case (state_q)
          IDLE: begin
            addr_q      <= startIn;
            shadowEnd_q <= endIn;
            if (go) begin
              state_q   <= RUNNING;
              syncRaw_q <= 1'b1;
            end
          end
          RUNNING: begin
            if (modeIn == 2'd0) begin
              state_q <= IDLE;
              addr_q  <= startIn;
            end else if (restart_all) begin
              addr_q      <= startIn;
              shadowEnd_q <= endIn;
              syncRaw_q   <= 1'b1;
            end else if (atEnd && (modeIn == 2'd2)) begin
              state_q <= IDLE;
              addr_q  <= startIn;
              done_q  <= 1'b1;
            end else if (atEnd) begin
              addr_q      <= startIn;
              shadowEnd_q <= endIn;
              syncRaw_q   <= 1'b1;
            end else begin
              addr_q <= addr_q + ADDR_WIDTH'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end

    assign read_address[i*ADDR_WIDTH +: ADDR_WIDTH] = addr_q;
    assign running[i]  = (state_q == RUNNING);
    assign done[i]     = done_q;
    assign sync_out[i] = syncPipe_q[SYNC_DELAY-1];
  end

endmodule

// File: tb/tb_multichannel_waveform_sequencer.sv
// Randomised bench for multichannel_waveform_sequencer against a window-position reference model.
module tb_multichannel_waveform_sequencer;

   localparam int NCH   = 4;
   localparam int AW    = 14;
   localparam int SD    = 3;
   localparam int DEPTH = 1 << AW;

   logic                    clock;
   logic                    reset;
   logic [NCH*AW-1:0]       startV;
   logic [NCH*(AW+1)-1:0]   endV;
   logic [NCH*2-1:0]        modeV;
   logic [NCH-1:0]          trigV;
   logic                    restartAll;
   logic [NCH*AW-1:0]       readAddress;
   logic [NCH-1:0]          runningV;
   logic [NCH-1:0]          doneV;
   logic [NCH-1:0]          configError;
   logic [NCH-1:0]          syncOut;

   int cfgStart [NCH];
   int cfgEnd   [NCH];
   int cfgMode  [NCH];
   bit cfgTrig  [NCH];
   bit cfgRestart;

   // Reference model: a channel plays shadow-start + position until the position reaches the window length.
   bit mRun     [NCH];
   int mAddr    [NCH];
   int mWinStart[NCH];
   int mWinEnd  [NCH];
   int mPos     [NCH];
   bit mDone    [NCH];
   bit mSyncHist[NCH][SD+1];

   int total = 0;
   int bad   = 0;

   multichannel_waveform_sequencer #(
      .NUM_CHANNELS(NCH),
      .ADDR_WIDTH  (AW),
      .SYNC_DELAY  (SD)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .start_address(startV),
      .end_address  (endV),
      .mode         (modeV),
      .trigger      (trigV),
      .restart_all  (restartAll),
      .read_address (readAddress),
      .running      (runningV),
      .done         (doneV),
      .config_error (configError),
      .sync_out     (syncOut)
   );

   // Free-running word clock, rising edges at 5, 15, 25 ...
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      total++;
      if (observed != expected) begin
         bad++;
         $display("[TB] FAIL %s got=%0d want=%0d at %0t", tag, observed, expected, $time);
      end
   endtask

   // Clears the model back to the post-reset picture.
   task automatic modelReset();
      for (int ch = 0; ch < NCH; ch++) begin
         mRun[ch] = 1'b0; mAddr[ch] = 0; mWinStart[ch] = 0; mWinEnd[ch] = 0;
         mPos[ch] = 0; mDone[ch] = 1'b0;
         for (int k = 0; k <= SD; k++) mSyncHist[ch][k] = 1'b0;
      end
   endtask

   // Advances the model across one rising edge using the inputs about to be presented.
   task automatic stepModel();
      for (int ch = 0; ch < NCH; ch++) begin
         int s = cfgStart[ch];
         int e = cfgEnd[ch];
         int m = cfgMode[ch];
         bit syncNow = 1'b0;
         bit doneNow = 1'b0;
         bit reload  = 1'b0;
         if (!mRun[ch]) begin
            reload = 1'b1;
            if (e > s && (m == 1 || (m >= 2 && cfgTrig[ch]))) begin
               mRun[ch] = 1'b1;
               syncNow  = 1'b1;
            end
         end else if (m == 0) begin
            mRun[ch] = 1'b0;
            reload   = 1'b1;
         end else if (cfgRestart) begin
            reload  = 1'b1;
            syncNow = 1'b1;
         end else if (mAddr[ch] == mWinEnd[ch] - 1) begin
            reload = 1'b1;
            if (m == 2) begin
               mRun[ch] = 1'b0;
               doneNow  = 1'b1;
            end else begin
               syncNow = 1'b1;
            end
         end else begin
            mPos[ch]++;
         end
         if (reload) begin
            mWinStart[ch] = s;
            mWinEnd[ch]   = e;
            mPos[ch]      = 0;
         end
         mAddr[ch] = (mWinStart[ch] + mPos[ch]) % DEPTH;
         mDone[ch] = doneNow;
         for (int k = SD; k > 0; k--) mSyncHist[ch][k] = mSyncHist[ch][k-1];
         mSyncHist[ch][0] = syncNow;
      end
   endtask

   task automatic checkAll();
      for (int ch = 0; ch < NCH; ch++) begin
         checkOutput($sformatf("addr%0d", ch), int'(readAddress[ch*AW +: AW]), mAddr[ch]);
         checkOutput($sformatf("running%0d", ch), int'(runningV[ch]), int'(mRun[ch]));
         checkOutput($sformatf("done%0d", ch), int'(doneV[ch]), int'(mDone[ch]));
         checkOutput($sformatf("syncOut%0d", ch), int'(syncOut[ch]), int'(mSyncHist[ch][SD]));
      end
   endtask

   // Presents the current configuration, checks the combinational error flag and steps the model.
   task automatic driveAndStep();
      for (int ch = 0; ch < NCH; ch++) begin
         startV[ch*AW +: AW]         = cfgStart[ch][AW-1:0];
         endV[ch*(AW+1) +: (AW+1)]   = cfgEnd[ch][AW:0];
         modeV[ch*2 +: 2]            = cfgMode[ch][1:0];
         trigV[ch]                   = cfgTrig[ch];
      end
      restartAll = cfgRestart;
      #1;
      for (int ch = 0; ch < NCH; ch++)
         checkOutput($sformatf("cfgErr%0d", ch), int'(configError[ch]), int'(cfgEnd[ch] <= cfgStart[ch]));
      stepModel();
      for (int ch = 0; ch < NCH; ch++) cfgTrig[ch] = 1'b0;
      cfgRestart = 1'b0;
   endtask

   task automatic applyStimulus();
      @(negedge clock);
      checkAll();
      driveAndStep();
   endtask

   // Drops reset between clock edges, checks the immediate clear, then releases on a falling edge.
   task automatic applyReset(input int holdCycles);
      @(negedge clock);
      #2;
      reset = 1'b0;
      modelReset();
      #1;
      checkAll();
      repeat (holdCycles) @(negedge clock);
      reset = 1'b1;
      driveAndStep();
   endtask

   task automatic waitAddr(input int ch, input int target, input int budget);
      int k = 0;
      while (mAddr[ch] != target && k < budget) begin
         applyStimulus();
         k++;
      end
      checkOutput($sformatf("reach%0d_%0d", ch, target), mAddr[ch], target);
   endtask

   task automatic randomConfig(input int ch);
      int s = $urandom_range(4, 60);
      cfgStart[ch] = s;
      if ($urandom_range(0, 9) == 0) cfgEnd[ch] = s - $urandom_range(0, 3);
      else                           cfgEnd[ch] = s + $urandom_range(1, 8);
      cfgMode[ch] = $urandom_range(0, 3);
   endtask

   initial begin
      reset      = 1'b0;
      startV     = '0;
      endV       = '0;
      modeV      = '0;
      trigV      = '0;
      restartAll = 1'b0;
      cfgRestart = 1'b0;
      for (int ch = 0; ch < NCH; ch++) begin
         cfgStart[ch] = 0; cfgEnd[ch] = 0; cfgMode[ch] = 0; cfgTrig[ch] = 1'b0;
      end
      modelReset();

      @(negedge clock);
      checkAll();
      cfgStart[0] = 4;  cfgEnd[0] = 8;     cfgMode[0] = 1;
      cfgStart[1] = 10; cfgEnd[1] = 13;    cfgMode[1] = 2;
      cfgStart[2] = 9;  cfgEnd[2] = 9;     cfgMode[2] = 1;
      cfgStart[3] = 0;  cfgEnd[3] = DEPTH; cfgMode[3] = 0;
      @(negedge clock);
      reset = 1'b1;
      driveAndStep();

      repeat (10) applyStimulus();
      cfgTrig[1] = 1'b1;
      applyStimulus();
      applyStimulus();
      cfgTrig[1] = 1'b1;
      applyStimulus();
      repeat (4) applyStimulus();
      cfgTrig[1] = 1'b1;
      repeat (6) applyStimulus();

      waitAddr(0, 5, 20);
      cfgStart[0] = 20; cfgEnd[0] = 22;
      repeat (8) applyStimulus();
      cfgStart[0] = 4; cfgEnd[0] = 8;
      waitAddr(0, 6, 20);
      cfgMode[0] = 0;
      applyStimulus();
      cfgMode[0] = 1;
      repeat (4) applyStimulus();

      cfgStart[2] = 30; cfgEnd[2] = 31; cfgMode[2] = 3;
      repeat (3) applyStimulus();
      cfgTrig[2] = 1'b1;
      repeat (5) applyStimulus();

      cfgMode[3] = 1;
      waitAddr(3, 100, 200);
      waitAddr(0, 6, 20);
      cfgRestart = 1'b1;
      repeat (6) applyStimulus();

      applyReset(2);
      repeat (6) applyStimulus();

      for (int cyc = 0; cyc < 2000; cyc++) begin
         for (int ch = 0; ch < NCH; ch++) begin
            if ($urandom_range(0, 29) == 0) randomConfig(ch);
            cfgTrig[ch] = ($urandom_range(0, 3) == 0);
         end
         cfgRestart = ($urandom_range(0, 49) == 0);
         if (cyc == 700 || cyc == 1400) applyReset($urandom_range(1, 3));
         else                           applyStimulus();
      end

      for (int ch = 0; ch < 3; ch++) begin
         cfgStart[ch] = 4 * ch + 1; cfgEnd[ch] = 4 * ch + 4; cfgMode[ch] = 1;
      end
      cfgStart[3] = 0; cfgEnd[3] = DEPTH; cfgMode[3] = 1;
      cfgRestart = 1'b1;
      applyStimulus();
      waitAddr(3, DEPTH - 1, DEPTH + 50);
      repeat (6) applyStimulus();
      @(negedge clock);
      checkAll();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
